// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller (divide hold, MEM wait with timeout, load-use, branch flush)
module pipe_ctrl #(
    parameter int DIV_CYCLES  = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stallreq_id,
    input  logic       div_start,
    input  logic       mem_req,
    input  logic       mem_ack,
    input  logic       br_taken,
    output logic [4:0] stall,
    output logic       br_flush,
    output logic       div_busy,
    output logic       div_done,
    output logic       mem_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state, state_next;
    logic [7:0] div_cnt, div_cnt_next, mem_cnt, mem_cnt_next;
    logic       mem_wait, timeout, mem_hold, div_hold, load_hold;

    // state, counters and registered divide status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            mem_cnt  <= '0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
        end else begin
            state    <= state_next;
            div_cnt  <= div_cnt_next;
            mem_cnt  <= mem_cnt_next;
            div_busy <= state_next == BUSY;
            div_done <= state_next == DONE;
        end
    end

    // divide sequencer: counter runs regardless of MEM stalls
    always_comb begin
        state_next   = state;
        div_cnt_next = div_cnt;
        case (state)
            IDLE: if (div_start) begin
                state_next   = BUSY;
                div_cnt_next = 8'(DIV_CYCLES - 2);
            end
            BUSY: if (div_cnt == 8'd0) state_next = DONE;
                  else div_cnt_next = div_cnt - 8'd1;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // hazard priority and MEM wait timeout; reset forces all pulses and holds off
    always_comb begin
        mem_wait     = mem_req & ~mem_ack;
        timeout      = mem_wait && mem_cnt == 8'(MEM_TIMEOUT - 1);
        mem_cnt_next = (!mem_wait || timeout) ? 8'd0 :
                       (mem_cnt == 8'(MEM_TIMEOUT)) ? mem_cnt : mem_cnt + 8'd1;
        mem_hold     = mem_wait & ~timeout;
        div_hold     = (state == IDLE && div_start) || state == BUSY;
        load_hold    = stallreq_id & ~br_taken;
        stall        = reset     ? 5'b00000 :
                       mem_hold  ? 5'b01111 :
                       div_hold  ? 5'b00111 :
                       load_hold ? 5'b00011 : 5'b00000;
        br_flush     = ~reset & br_taken & ~stall[2];
        mem_err      = ~reset & timeout;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against a timestamp-based model
module tb_pipe_ctrl;
    localparam int DIV = 32;
    localparam int MT  = 16;

    logic       clk = 1'b0;
    logic       reset, stallreq_id, div_start, mem_req, mem_ack, br_taken;
    logic [4:0] stall;
    logic       br_flush, div_busy, div_done, mem_err;

    pipe_ctrl #(.DIV_CYCLES(DIV), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset), .stallreq_id(stallreq_id), .div_start(div_start),
        .mem_req(mem_req), .mem_ack(mem_ack), .br_taken(br_taken),
        .stall(stall), .br_flush(br_flush), .div_busy(div_busy),
        .div_done(div_done), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int   vectors = 0, errors = 0, checks = 0;
    int   cyc = 0, t0 = -1, waitrun = 0;
    bit   armed = 0;
    logic [4:0] s_stall;
    logic       s_flush, s_busy, s_done, s_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit sid, input bit ds, input bit mr, input bit ma, input bit bt);
        reset = r; stallreq_id = sid; div_start = ds; mem_req = mr; mem_ack = ma; br_taken = bt;
    endtask

    // one cycle: compare against model mid-cycle, then advance the model at the edge
    task automatic tick();
        int el;
        bit busy, done, idle, mw, tmo;
        logic [4:0] est;
        @(negedge clk);
        el   = (t0 >= 0) ? cyc - t0 : -1;
        busy = el >= 1 && el <= DIV - 1;
        done = el == DIV;
        idle = !(busy || done);
        mw   = mem_req && !mem_ack;
        tmo  = mw && waitrun == MT - 1;
        est  = reset ? 5'b00000 :
               (mw && !tmo) ? 5'b01111 :
               ((idle && div_start) || busy) ? 5'b00111 :
               (stallreq_id && !br_taken) ? 5'b00011 : 5'b00000;
        s_stall = stall; s_flush = br_flush; s_busy = div_busy; s_done = div_done; s_err = mem_err;
        vectors++;
        chk("stall", int'(stall), int'(est));
        chk("br_flush", int'(br_flush), int'(!reset && br_taken && !est[2]));
        chk("mem_err", int'(mem_err), int'(!reset && tmo));
        if (armed) begin
            chk("div_busy", int'(div_busy), int'(busy));
            chk("div_done", int'(div_done), int'(done));
        end
        @(posedge clk);
        if (reset) begin
            t0 = -1; waitrun = 0;
        end else begin
            if (idle && div_start) t0 = cyc;
            else if (done) t0 = -1;
            waitrun = (mw && !tmo) ? waitrun + 1 : 0;
        end
        cyc++;
        armed = 1;
        #1;
    endtask

    initial begin
        // reset with noisy inputs
        drive(1, 1, 1, 1, 0, 1); tick();
        chk("rst_stall", int'(s_stall), 0); chk("rst_flush", int'(s_flush), 0); chk("rst_err", int'(s_err), 0);
        tick();
        chk("rst_busy", int'(s_busy), 0); chk("rst_done", int'(s_done), 0);
        // load-use vs branch
        drive(0, 1, 0, 0, 0, 0); tick();
        chk("load_use", int'(s_stall), 5'b00011); chk("load_noflush", int'(s_flush), 0);
        drive(0, 1, 0, 0, 0, 1); tick();
        chk("br_over_load", int'(s_stall), 0); chk("br_flush", int'(s_flush), 1);
        // divide sequence
        drive(0, 0, 1, 0, 0, 0); tick();
        chk("div_T", int'(s_stall), 5'b00111);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DIV - 1; i++) begin
            tick();
            if (i == 1 || i == DIV - 1) begin
                chk("div_hold", int'(s_stall), 5'b00111); chk("div_busy_on", int'(s_busy), 1);
            end
        end
        tick();
        chk("div_done", int'(s_done), 1); chk("div_rel", int'(s_stall), 0); chk("div_busy_off", int'(s_busy), 0);
        tick();
        chk("div_done_pulse", int'(s_done), 0);
        // short MEM wait
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("mem_wait", int'(s_stall), 5'b01111);
        end
        drive(0, 0, 0, 1, 1, 0); tick();
        chk("mem_ack", int'(s_stall), 0); chk("mem_no_err", int'(s_err), 0);
        // MEM timeout and restart
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= MT - 1; i++) begin
            tick();
            if (i == MT - 1) begin
                chk("mem_pre_to", int'(s_stall), 5'b01111); chk("mem_pre_err", int'(s_err), 0);
            end
        end
        tick();
        chk("mem_timeout", int'(s_err), 1); chk("mem_to_rel", int'(s_stall), 0);
        tick();
        chk("mem_restart", int'(s_stall), 5'b01111); chk("mem_restart_err", int'(s_err), 0);
        // MEM wait overlapping a divide
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= DIV - 1; i++) begin
            if (i == 4) drive(0, 0, 0, 1, 0, 0);
            if (i == 10) drive(0, 0, 0, 0, 0, 0);
            tick();
            if (i == 5) chk("ovl_mem", int'(s_stall), 5'b01111);
        end
        tick();
        chk("ovl_done", int'(s_done), 1);
        // reset mid-BUSY
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("rst_mid_busy", int'(s_busy), 0); chk("rst_mid_stall", int'(s_stall), 0);
        for (int i = 0; i < 40; i++) begin
            tick(); chk("rst_no_done", int'(s_done), 0);
        end
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(15) == 0,
                  $urandom_range(1) == 0, $urandom_range(7) == 0, $urandom_range(5) == 0);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: DIV_CYCLES, 32, cycles a divide holds EX; legal range 2..255.
REQ-002 Parameter: MEM_TIMEOUT, 16, max consecutive MEM wait cycles before forced release; legal range 2..255.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: stallreq_id  in  1  load-use hazard detected in ID (combinational).
REQ-006 Port: div_start  in  1  EX holds a divide instruction.
REQ-007 Port: mem_req  in  1  MEM stage issues a data-memory access.
REQ-008 Port: mem_ack  in  1  data memory completes the access this cycle.
REQ-009 Port: br_taken  in  1  EX resolves a taken branch or jump.
REQ-010 Port: stall  out  5  per-stage hold: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB.
REQ-011 Port: br_flush  out  1  flush IF/ID and ID/EX this cycle.
REQ-012 Port: div_busy  out  1  divide sequence in progress.
REQ-013 Port: div_done  out  1  one-cycle pulse: divide result valid and EX releases.
REQ-014 Port: mem_err  out  1  one-cycle pulse: MEM wait timed out.

Function
REQ-015 stall, br_flush and mem_err SHALL be combinational from the registered state and the current inputs; all other outputs SHALL be registered.
REQ-016 The divide FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 IDLE with div_start=1 SHALL go to BUSY and load the divide counter with DIV_CYCLES-2.
REQ-018 BUSY SHALL decrement the counter each cycle and go to DONE when the counter is 0.
REQ-019 DONE SHALL last exactly one cycle, SHALL ignore div_start and SHALL return to IDLE.
REQ-020 div_busy SHALL be 1 in BUSY; div_done SHALL be 1 in DONE only.
REQ-021 The divide counter SHALL keep running while a MEM stall is active.
REQ-022 mem_wait (raw) SHALL be mem_req & ~mem_ack.
REQ-023 The mem-wait counter SHALL count consecutive mem_wait cycles, clear when mem_wait=0 and saturate at MEM_TIMEOUT.
REQ-024 When mem_wait=1 and the mem-wait counter equals MEM_TIMEOUT-1, mem_err SHALL pulse, the MEM stall SHALL be released and the counter SHALL clear.
REQ-025 div_hold SHALL be (state IDLE & div_start) | state BUSY.
REQ-026 load_hold SHALL be stallreq_id & ~br_taken; a taken branch overrides load-use because the ID instruction is wrong-path.
REQ-027 stall encoding SHALL be strict priority:
- MEM stall (mem_wait & no timeout): 5'b01111
- else div_hold: 5'b00111
- else load_hold: 5'b00011
- else: 5'b00000
REQ-028 Each stall encoding SHALL make the lowest held register's successor receive a bubble, per the stage convention stall[n]=1 & stall[n+1]=0.
REQ-029 br_flush SHALL be br_taken & ~stall[2]; a branch in a held EX stage SHALL NOT flush until EX advances.
REQ-030 Out-of-range DIV_CYCLES or MEM_TIMEOUT is unsupported; behaviour is undefined.

Reset
REQ-031 With reset=1 at a clock edge, the following SHALL apply on the next cycle:
- divide FSM = IDLE, both counters = 0
- div_busy = 0, div_done = 0
REQ-032 While reset=1, stall SHALL be 5'b00000 and br_flush, mem_err SHALL be 0, regardless of other inputs.
REQ-033 Reset asserted mid-divide or mid-wait SHALL abort the sequence; no div_done or mem_err SHALL follow.

Verification
REQ-034 Divide, DIV_CYCLES=32:
- div_start=1 at cycle T -> stall=00111 for T..T+31
- cycle T+32: div_done=1, stall=00000
- div_busy=1 for T+1..T+31
REQ-035 Load-use vs branch:
- stallreq_id=1 alone -> stall=00011, br_flush=0
- stallreq_id=1 with br_taken=1 -> stall=00000, br_flush=1
REQ-036 MEM wait:
- mem_req=1, mem_ack=0 for 3 cycles, then mem_ack=1 -> stall=01111 for 3 cycles, then 00000, mem_err never 1
REQ-037 MEM timeout, MEM_TIMEOUT=16:
- mem_req=1, mem_ack held 0 -> stall=01111 for 15 cycles
- 16th cycle: mem_err=1, stall=00000
- the counter restarts afterwards
REQ-038 Overlap and reset:
- MEM wait during BUSY -> stall=01111; the divide counter still expires on schedule
- reset=1 mid-BUSY -> next cycle div_busy=0, stall=00000, no div_done
